// File: rtl/debounce_edge_det.sv
// rtl/debounce_edge_det.sv - debouncer with synchronizer, stability counter and rise/fall one-shots
//
// Conditions a raw single-bit level (typically a button or switch sampled by an
// upstream flip-flop) into a clean debounced level plus one-cycle edge events.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous, active-high reset
//   d_in  - raw level from the upstream flip-flop
//   q     - debounced level (registered)
//   qbar  - complement of q (registered alongside q)
//   rise  - one-cycle pulse in the cycle q goes 0->1
//   fall  - one-cycle pulse in the cycle q goes 1->0
//   busy  - high while a new level is being qualified
module debounce_edge_det #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Last count value before acceptance; the counter never goes beyond it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic             sync0;
  logic             sync1;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             q_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  logic             busy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      state <= IDLE_LOW;
      cnt   <= CNT_ZERO;
      q     <= 1'b0;
      qbar  <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      sync0 <= d_in;
      sync1 <= sync0;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      qbar  <= ~q_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
    end
  end

  // The entry sample plus STABLE_CYCLES agreeing samples in WAIT accept the
  // new level; any disagreeing sample in WAIT drops back to the old IDLE state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;

    case (state)
      IDLE_LOW: begin
        cnt_nxt = CNT_ZERO;
        if (sync1) begin
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (!sync1) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = CNT_ZERO;
          q_nxt     = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        cnt_nxt = CNT_ZERO;
        if (!sync1) begin
          state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (sync1) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = CNT_ZERO;
          q_nxt     = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = CNT_ZERO;
        q_nxt     = 1'b0;
      end
    endcase

    // busy is registered, so it follows the state being entered.
    busy_nxt = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
  end

endmodule

// File: tb/tb_debounce_edge_det.sv
// tb/tb_debounce_edge_det.sv - scoreboard bench for debounce_edge_det
module tb_debounce_edge_det;

  localparam int STABLE = 8;
  localparam int LAT    = STABLE + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_in = 1'b1;
  logic q, qbar, rise, fall, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int edge_no;
    bit is_rise;
  } exp_t;

  exp_t sb[$];

  debounce_edge_det #(
    .STABLE_CYCLES(STABLE),
    .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .d_in(d_in),
    .q   (q),
    .qbar(qbar),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Pulse monitor: every rise/fall must match the oldest scoreboard entry.
  always @(posedge clk) begin
    #1;
    check("qbar_compl", qbar, !q);
    check("no_dual_pulse", rise & fall, 0);
    if (rise || fall) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {rise, fall}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_edge", cyc, e.edge_no);
        check("pulse_kind", rise, e.is_rise);
        check("pulse_q", q, e.is_rise);
      end
    end
  end

  // Returns at the negedge following edge n.
  task automatic to_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // d_in has just settled at lvl and is first sampled by sync0 at edge k.
  task automatic expect_accept(input int k, input bit lvl);
    sb.push_back('{k + LAT, lvl});
    to_edge(k + 2);
    check("busy_enter", busy, 1);
    to_edge(k + LAT - 1);
    check("busy_pre", busy, 1);
    check("q_pre", q, !lvl);
    to_edge(k + LAT);
    check("busy_done", busy, 0);
    check("q_post", q, lvl);
    check("qbar_post", qbar, !lvl);
    to_edge(k + LAT + 1);
    check("pulse_one_cycle", rise | fall, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int k;
    int busy_changes;
    logic busy_prev;

    // Reset held for three edges with d_in high.
    for (int i = 1; i <= 3; i++) begin
      to_edge(i);
      check("rst_q", q, 0);
      check("rst_qbar", qbar, 1);
      check("rst_rise", rise, 0);
      check("rst_fall", fall, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0;
    expect_accept(cyc + 1, 1'b1);

    // Clean fall.
    d_in = 1'b0;
    expect_accept(cyc + 1, 1'b0);

    // Glitch: four cycles high then back low.
    to_edge(cyc + 2);
    d_in = 1'b1;
    k = cyc + 1;
    to_edge(k + 2);
    check("glitch_busy", busy, 1);
    to_edge(k + 3);
    d_in = 1'b0;
    to_edge(k + 5);
    check("glitch_busy_hold", busy, 1);
    to_edge(k + 6);
    check("glitch_abort", busy, 0);
    to_edge(k + 20);
    check("glitch_q", q, 0);

    // Bounce 1,0,1,0,1 then hold high.
    d_in = 1'b1; @(negedge clk);
    d_in = 1'b0; @(negedge clk);
    d_in = 1'b1; @(negedge clk);
    d_in = 1'b0; @(negedge clk);
    d_in = 1'b1;
    expect_accept(cyc + 1, 1'b1);

    // Reset in WAIT_LOW with cnt=5.
    to_edge(cyc + 2);
    d_in = 1'b0;
    k = cyc + 1;
    to_edge(k + 7);
    check("mid_busy", busy, 1);
    check("mid_q", q, 1);
    rst = 1'b1;
    d_in = 1'b1;
    to_edge(k + 8);
    check("mid_rst_q", q, 0);
    check("mid_rst_qbar", qbar, 1);
    check("mid_rst_fall", fall, 0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    expect_accept(cyc + 1, 1'b1);

    // Toggle every cycle: q holds, busy keeps toggling.
    busy_changes = 0;
    busy_prev = busy;
    for (int i = 0; i < 40; i++) begin
      d_in = ~d_in;
      @(negedge clk);
      if (busy != busy_prev) busy_changes++;
      busy_prev = busy;
      check("toggle_q", q, 1);
    end
    check("toggle_busy_active", busy_changes > 10, 1);
    d_in = 1'b1;
    to_edge(cyc + 20);
    check("final_q", q, 1);
    check("final_busy", busy, 0);
    check("final_sb", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule
